// File: rtl/id_ex_reg_if.sv
// Decode-to-execute pipeline register bundle: D-stage inputs, E-stage outputs and hazard status.
// The master side drives stall/flush and the D slot; the slave side is the register itself.
interface id_ex_reg_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
);
  logic               stall;
  logic               flush;

  logic               valid_d;
  logic               reg_write_d;
  logic               memto_reg_d;
  logic               mem_write_d;
  logic               alu_src_d;
  logic               reg_dst_d;
  logic               branch_d;
  logic [1:0]         alu_op_d;
  logic [5:0]         funct_d;
  logic [WIDTH-1:0]   rd1_d;
  logic [WIDTH-1:0]   rd2_d;
  logic [WIDTH-1:0]   sign_imm_d;
  logic [WIDTH-1:0]   pc_plus4_d;
  logic [REGBITS-1:0] rs_d;
  logic [REGBITS-1:0] rt_d;
  logic [REGBITS-1:0] rd_d;

  logic               valid_e;
  logic               reg_write_e;
  logic               memto_reg_e;
  logic               mem_write_e;
  logic               alu_src_e;
  logic               reg_dst_e;
  logic               branch_e;
  logic [1:0]         alu_op_e;
  logic [5:0]         funct_e;
  logic [WIDTH-1:0]   rd1_e;
  logic [WIDTH-1:0]   rd2_e;
  logic [WIDTH-1:0]   sign_imm_e;
  logic [WIDTH-1:0]   pc_plus4_e;
  logic [REGBITS-1:0] rs_e;
  logic [REGBITS-1:0] rt_e;
  logic [REGBITS-1:0] rd_e;

  logic               load_use;
  logic               stall_fd;
  logic [15:0]        bubble_count;

  modport master (
    output stall, flush,
    output valid_d, reg_write_d, memto_reg_d, mem_write_d, alu_src_d, reg_dst_d, branch_d,
    output alu_op_d, funct_d, rd1_d, rd2_d, sign_imm_d, pc_plus4_d, rs_d, rt_d, rd_d,
    input  valid_e, reg_write_e, memto_reg_e, mem_write_e, alu_src_e, reg_dst_e, branch_e,
    input  alu_op_e, funct_e, rd1_e, rd2_e, sign_imm_e, pc_plus4_e, rs_e, rt_e, rd_e,
    input  load_use, stall_fd, bubble_count
  );

  modport slave (
    input  stall, flush,
    input  valid_d, reg_write_d, memto_reg_d, mem_write_d, alu_src_d, reg_dst_d, branch_d,
    input  alu_op_d, funct_d, rd1_d, rd2_d, sign_imm_d, pc_plus4_d, rs_d, rt_d, rd_d,
    output valid_e, reg_write_e, memto_reg_e, mem_write_e, alu_src_e, reg_dst_e, branch_e,
    output alu_op_e, funct_e, rd1_e, rd2_e, sign_imm_e, pc_plus4_e, rs_e, rt_e, rd_e,
    output load_use, stall_fd, bubble_count
  );
endinterface

// File: rtl/id_ex_reg.sv
// D-to-E pipeline register with hold, flush, load-use bubble insertion and a
// saturating bubble counter. Priority each edge: stall > flush > load-use > load.
module id_ex_reg #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input logic         clk,
  input logic         rst,
  id_ex_reg_if.slave  bus
);

  logic        load_use;
  logic        bubble;
  logic [15:0] bubble_count;

  // Only a valid load in E against a valid consumer in D stalls; $0 is never a real dependency.
  assign load_use = bus.valid_e & bus.memto_reg_e & bus.valid_d &
                    (bus.rt_e != {REGBITS{1'b0}}) &
                    ((bus.rt_e == bus.rs_d) | (bus.rt_e == bus.rt_d));

  assign bubble           = bus.flush | load_use;
  assign bus.load_use     = load_use;
  assign bus.stall_fd     = bus.stall | load_use;
  assign bus.bubble_count = bubble_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_e     <= 1'b0;
      bus.reg_write_e <= 1'b0;
      bus.memto_reg_e <= 1'b0;
      bus.mem_write_e <= 1'b0;
      bus.alu_src_e   <= 1'b0;
      bus.reg_dst_e   <= 1'b0;
      bus.branch_e    <= 1'b0;
      bus.alu_op_e    <= 2'b00;
      bus.funct_e     <= 6'b0;
      bus.rd1_e       <= {WIDTH{1'b0}};
      bus.rd2_e       <= {WIDTH{1'b0}};
      bus.sign_imm_e  <= {WIDTH{1'b0}};
      bus.pc_plus4_e  <= {WIDTH{1'b0}};
      bus.rs_e        <= {REGBITS{1'b0}};
      bus.rt_e        <= {REGBITS{1'b0}};
      bus.rd_e        <= {REGBITS{1'b0}};
    end else if (!bus.stall) begin
      if (bubble) begin
        // An all-zero slot is an ALU add with no write-back and no memory effect.
        bus.valid_e     <= 1'b0;
        bus.reg_write_e <= 1'b0;
        bus.memto_reg_e <= 1'b0;
        bus.mem_write_e <= 1'b0;
        bus.alu_src_e   <= 1'b0;
        bus.reg_dst_e   <= 1'b0;
        bus.branch_e    <= 1'b0;
        bus.alu_op_e    <= 2'b00;
        bus.funct_e     <= 6'b0;
        bus.rd1_e       <= {WIDTH{1'b0}};
        bus.rd2_e       <= {WIDTH{1'b0}};
        bus.sign_imm_e  <= {WIDTH{1'b0}};
        bus.pc_plus4_e  <= {WIDTH{1'b0}};
        bus.rs_e        <= {REGBITS{1'b0}};
        bus.rt_e        <= {REGBITS{1'b0}};
        bus.rd_e        <= {REGBITS{1'b0}};
      end else begin
        bus.valid_e     <= bus.valid_d;
        bus.reg_write_e <= bus.reg_write_d;
        bus.memto_reg_e <= bus.memto_reg_d;
        bus.mem_write_e <= bus.mem_write_d;
        bus.alu_src_e   <= bus.alu_src_d;
        bus.reg_dst_e   <= bus.reg_dst_d;
        bus.branch_e    <= bus.branch_d;
        bus.alu_op_e    <= bus.alu_op_d;
        bus.funct_e     <= bus.funct_d;
        bus.rd1_e       <= bus.rd1_d;
        bus.rd2_e       <= bus.rd2_d;
        bus.sign_imm_e  <= bus.sign_imm_d;
        bus.pc_plus4_e  <= bus.pc_plus4_d;
        bus.rs_e        <= bus.rs_d;
        bus.rt_e        <= bus.rt_d;
        bus.rd_e        <= bus.rd_d;
      end
    end
  end

  // A flush that coincides with a load-use hazard is still a single bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= 16'h0000;
    end else if (!bus.stall && bubble && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: each edge's expected E slot and bubble count is
// queued when stimulus is applied and popped once the edge has occurred.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid, rw, m2r, mw, asrc, rdst, br;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } stage_t;

  typedef struct packed {
    stage_t      e;
    logic [15:0] cnt;
  } sb_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   stall = 1'b0;
  logic   flush = 1'b0;
  stage_t d = '0;
  stage_t dut_e;
  stage_t m_e = '0;
  logic [15:0] m_cnt = 16'h0000;
  sb_t    sbq[$];
  int     n_vec = 0;
  int     n_err = 0;

  id_ex_reg_if #(.WIDTH(32), .REGBITS(5)) bus ();

  id_ex_reg #(.WIDTH(32), .REGBITS(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.valid_d     = d.valid;
  assign bus.reg_write_d = d.rw;
  assign bus.memto_reg_d = d.m2r;
  assign bus.mem_write_d = d.mw;
  assign bus.alu_src_d   = d.asrc;
  assign bus.reg_dst_d   = d.rdst;
  assign bus.branch_d    = d.br;
  assign bus.alu_op_d    = d.aluop;
  assign bus.funct_d     = d.funct;
  assign bus.rd1_d       = d.rd1;
  assign bus.rd2_d       = d.rd2;
  assign bus.sign_imm_d  = d.imm;
  assign bus.pc_plus4_d  = d.pc4;
  assign bus.rs_d        = d.rs;
  assign bus.rt_d        = d.rt;
  assign bus.rd_d        = d.rd;

  assign dut_e = {bus.valid_e, bus.reg_write_e, bus.memto_reg_e, bus.mem_write_e,
                  bus.alu_src_e, bus.reg_dst_e, bus.branch_e, bus.alu_op_e, bus.funct_e,
                  bus.rd1_e, bus.rd2_e, bus.sign_imm_e, bus.pc_plus4_e,
                  bus.rs_e, bus.rt_e, bus.rd_e};

  function automatic logic model_lu();
    return m_e.valid & m_e.m2r & d.valid & (m_e.rt != 5'd0) &
           ((m_e.rt == d.rs) | (m_e.rt == d.rt));
  endfunction

  // Predict the slot for the coming edge, queue it, then advance to just after that edge.
  task automatic cycle();
    sb_t s;
    s.e   = m_e;
    s.cnt = m_cnt;
    if (!stall) begin
      if (flush | model_lu()) begin
        s.e = '0;
        if (m_cnt != 16'hFFFF) s.cnt = m_cnt + 16'd1;
      end else begin
        s.e = d;
      end
    end
    sbq.push_back(s);
    m_e   = s.e;
    m_cnt = s.cnt;
    @(posedge clk);
    #1;
  endtask

  function automatic stage_t mk(logic m2r, logic rw, logic [1:0] aluop, logic [5:0] funct,
                                logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rd1, logic [31:0] rd2);
    stage_t t;
    t = '0;
    t.valid = 1'b1; t.rw = rw; t.m2r = m2r; t.asrc = m2r; t.rdst = ~m2r;
    t.aluop = aluop; t.funct = funct; t.rs = rs; t.rt = rt; t.rd = rd;
    t.rd1 = rd1; t.rd2 = rd2; t.imm = 32'h0000_0004; t.pc4 = 32'h0040_0010;
    return t;
  endfunction

  task automatic test_reset();
    sb_t s;
    #3;
    n_vec++;
    if (dut_e !== '0 || bus.bubble_count !== 16'h0 || bus.load_use !== 1'b0 || bus.stall_fd !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init e=%h cnt=%h lu=%b sfd=%b, want all 0", dut_e, bus.bubble_count, bus.load_use, bus.stall_fd);
    end
    rst = 1'b0;
    flush = 1'b1;
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.bubble_count !== s.cnt) begin
      n_err++; $display("FAIL reset_flush e=%h cnt=%0d want e=%h cnt=%0d", dut_e, bus.bubble_count, s.e, s.cnt);
    end
    flush = 1'b0;
    d = mk(1'b0, 1'b1, 2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.bubble_count !== s.cnt) begin
      n_err++; $display("FAIL reset_add e=%h cnt=%0d want e=%h cnt=%0d", dut_e, bus.bubble_count, s.e, s.cnt);
    end
    n_vec++;
    if (bus.alu_op_e !== 2'b10 || bus.funct_e !== 6'b100000 || bus.rd1_e !== 32'd5 || bus.valid_e !== 1'b1) begin
      n_err++; $display("FAIL reset_add_fields aluop=%b funct=%b rd1=%0d valid=%b want 10 100000 5 1",
                        bus.alu_op_e, bus.funct_e, bus.rd1_e, bus.valid_e);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (dut_e !== '0 || bus.bubble_count !== 16'h0) begin
      n_err++; $display("FAIL reset_async e=%h cnt=%h want 0 0", dut_e, bus.bubble_count);
    end
    rst = 1'b0;
    m_e = '0;
    m_cnt = 16'h0;
  endtask

  task automatic test_load_use();
    sb_t s;
    logic [15:0] c0;
    d = mk(1'b1, 1'b1, 2'b00, 6'b0, 5'd1, 5'd8, 5'd0, 32'd100, 32'd0);
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.bubble_count !== s.cnt) begin
      n_err++; $display("FAIL lu_load e=%h cnt=%0d want e=%h cnt=%0d", dut_e, bus.bubble_count, s.e, s.cnt);
    end
    d = mk(1'b0, 1'b1, 2'b10, 6'b100000, 5'd8, 5'd9, 5'd10, 32'd11, 32'd12);
    #1;
    n_vec++;
    if (bus.load_use !== 1'b1 || bus.stall_fd !== 1'b1 || model_lu() !== 1'b1) begin
      n_err++; $display("FAIL lu_flag lu=%b sfd=%b want 1 1", bus.load_use, bus.stall_fd);
    end
    c0 = m_cnt;
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.bubble_count !== s.cnt) begin
      n_err++; $display("FAIL lu_bubble e=%h cnt=%0d want e=%h cnt=%0d", dut_e, bus.bubble_count, s.e, s.cnt);
    end
    n_vec++;
    if (bus.valid_e !== 1'b0 || bus.reg_write_e !== 1'b0 || bus.alu_op_e !== 2'b00 ||
        bus.bubble_count !== c0 + 16'd1 || bus.load_use !== 1'b0) begin
      n_err++; $display("FAIL lu_bubble_fields valid=%b rw=%b aluop=%b cnt=%0d lu=%b want 0 0 00 %0d 0",
                        bus.valid_e, bus.reg_write_e, bus.alu_op_e, bus.bubble_count, bus.load_use, c0 + 16'd1);
    end
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.rs_e !== 5'd8 || bus.valid_e !== 1'b1) begin
      n_err++; $display("FAIL lu_reissue e=%h rs=%0d want e=%h rs=8", dut_e, bus.rs_e, s.e);
    end
  endtask

  task automatic test_no_false_hazard();
    sb_t s;
    d = mk(1'b1, 1'b1, 2'b00, 6'b0, 5'd4, 5'd0, 5'd0, 32'd1, 32'd2);
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e) begin
      n_err++; $display("FAIL nf_load0 e=%h want %h", dut_e, s.e);
    end
    d = mk(1'b0, 1'b1, 2'b10, 6'b100000, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0);
    #1;
    n_vec++;
    if (bus.load_use !== 1'b0 || model_lu() !== 1'b0) begin
      n_err++; $display("FAIL nf_reg0 lu=%b want 0", bus.load_use);
    end
    d = mk(1'b0, 1'b1, 2'b10, 6'b100000, 5'd3, 5'd9, 5'd9, 32'd3, 32'd4);
    cycle();
    s = sbq.pop_front();
    d = mk(1'b0, 1'b1, 2'b10, 6'b100000, 5'd9, 5'd2, 5'd6, 32'd0, 32'd0);
    #1;
    n_vec++;
    if (dut_e !== s.e || bus.load_use !== 1'b0) begin
      n_err++; $display("FAIL nf_nonload e=%h lu=%b want e=%h lu=0", dut_e, bus.load_use, s.e);
    end
    d = mk(1'b1, 1'b1, 2'b00, 6'b0, 5'd1, 5'd9, 5'd0, 32'd0, 32'd0);
    cycle();
    s = sbq.pop_front();
    d = mk(1'b0, 1'b1, 2'b10, 6'b100000, 5'd9, 5'd9, 5'd7, 32'd21, 32'd22);
    d.valid = 1'b0;
    #1;
    n_vec++;
    if (dut_e !== s.e || bus.load_use !== 1'b0 || bus.stall_fd !== 1'b0) begin
      n_err++; $display("FAIL nf_invalid e=%h lu=%b sfd=%b want e=%h 0 0", dut_e, bus.load_use, bus.stall_fd, s.e);
    end
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.valid_e !== 1'b0 || bus.rs_e !== 5'd9 || bus.rd1_e !== 32'd21) begin
      n_err++; $display("FAIL nf_invalid_pass e=%h want %h (valid 0 rs 9)", dut_e, s.e);
    end
  endtask

  task automatic test_stall_over_flush();
    sb_t s;
    logic [15:0] c0;
    d = mk(1'b0, 1'b1, 2'b10, 6'b100010, 5'd2, 5'd3, 5'd4, 32'd50, 32'd8);
    cycle();
    s = sbq.pop_front();
    c0 = m_cnt;
    d = mk(1'b0, 1'b1, 2'b01, 6'b0, 5'd5, 5'd6, 5'd0, 32'd0, 32'd0);
    stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (bus.stall_fd !== 1'b1) begin
        n_err++; $display("FAIL sf_stall_fd cyc=%0d sfd=%b want 1", i, bus.stall_fd);
      end
      cycle();
      s = sbq.pop_front(); n_vec++;
      if (dut_e !== s.e || bus.funct_e !== 6'b100010 || bus.bubble_count !== c0) begin
        n_err++; $display("FAIL sf_hold cyc=%0d funct=%b cnt=%0d want 100010 %0d", i, bus.funct_e, bus.bubble_count, c0);
      end
    end
    stall = 1'b0;
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.valid_e !== 1'b0 || bus.bubble_count !== c0 + 16'd1) begin
      n_err++; $display("FAIL sf_flush valid=%b cnt=%0d want 0 %0d", bus.valid_e, bus.bubble_count, c0 + 16'd1);
    end
    flush = 1'b0;
  endtask

  task automatic test_flush_load_use();
    sb_t s;
    logic [15:0] c0;
    d = mk(1'b1, 1'b1, 2'b00, 6'b0, 5'd1, 5'd8, 5'd0, 32'd0, 32'd0);
    cycle();
    s = sbq.pop_front();
    d = mk(1'b0, 1'b1, 2'b10, 6'b100000, 5'd8, 5'd2, 5'd12, 32'd1, 32'd1);
    flush = 1'b1;
    #1;
    n_vec++;
    if (dut_e !== s.e || bus.load_use !== 1'b1 || bus.stall_fd !== 1'b1) begin
      n_err++; $display("FAIL fl_flag lu=%b sfd=%b want 1 1", bus.load_use, bus.stall_fd);
    end
    c0 = m_cnt;
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.valid_e !== 1'b0 || bus.bubble_count !== c0 + 16'd1) begin
      n_err++; $display("FAIL fl_once valid=%b cnt=%0d want 0 %0d", bus.valid_e, bus.bubble_count, c0 + 16'd1);
    end
    flush = 1'b0;
    cycle();
    s = sbq.pop_front(); n_vec++;
    if (dut_e !== s.e || bus.bubble_count !== s.cnt) begin
      n_err++; $display("FAIL fl_after e=%h cnt=%0d want e=%h cnt=%0d", dut_e, bus.bubble_count, s.e, s.cnt);
    end
  endtask

  task automatic test_back_to_back();
    sb_t s;
    for (int i = 0; i < 40; i++) begin
      d = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom), $urandom, $urandom);
      d.valid = ($urandom_range(0, 7) != 0);
      d.mw    = 1'($urandom_range(0, 1));
      d.br    = 1'($urandom_range(0, 1));
      d.pc4   = 32'h0040_0000 + 32'(4 * i);
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 4) == 0);
      #1;
      n_vec++;
      if (bus.load_use !== model_lu() || bus.stall_fd !== (stall | model_lu())) begin
        n_err++; $display("FAIL b2b_flags i=%0d lu=%b sfd=%b want %b %b", i, bus.load_use, bus.stall_fd,
                          model_lu(), stall | model_lu());
      end
      cycle();
      s = sbq.pop_front(); n_vec++;
      if (dut_e !== s.e || bus.bubble_count !== s.cnt) begin
        n_err++; $display("FAIL b2b i=%0d e=%h cnt=%0d want e=%h cnt=%0d", i, dut_e, bus.bubble_count, s.e, s.cnt);
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    sb_t s;
    flush = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      cycle();
      s = sbq.pop_front();
    end
    n_vec++;
    if (bus.bubble_count !== 16'hFFFF || bus.bubble_count !== s.cnt) begin
      n_err++; $display("FAIL sat_reach cnt=%h want ffff", bus.bubble_count);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      s = sbq.pop_front(); n_vec++;
      if (bus.bubble_count !== 16'hFFFF || dut_e !== s.e) begin
        n_err++; $display("FAIL sat_hold i=%0d cnt=%h want ffff", i, bus.bubble_count);
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_stall_over_flush();
    test_flush_load_use();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between the decode (D) and execute (E) stages of the MIPS pipeline. It captures the decoded control word from decode, including `AluOp` and `Funct` for the ALU-control decoder in E, along with the operands and register specifiers. It supports hold (stall), flush (bubble), and built-in load-use hazard detection with automatic bubble insertion. It also keeps a saturating bubble counter for performance monitoring.

## Interface
- `WIDTH`, 32, datapath width
- `REGBITS`, 5, register-specifier width

- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state immediately.
- `Stall` in 1: downstream hold request; E contents are frozen.
- `Flush` in 1: load a bubble into E (branch/jump squash).
- `ValidD` in 1: the D-stage slot holds a real instruction.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `AluSrcD`, `RegDstD`, `BranchD` in 1 each: main-decoder controls.
- `AluOpD` in 2, `FunctD` in 6: ALU-control inputs.
- `RD1D`, `RD2D`, `SignImmD`, `PCPlus4D` in WIDTH: operands.
- `RsD`, `RtD`, `RdD` in REGBITS: register specifiers.
- `...E` out: registered copies of every D input above, including `ValidE`.
- `LoadUse` out 1: combinational load-use hazard flag.
- `StallFD` out 1: freeze for the fetch and decode registers; equals `Stall | LoadUse`.
- `BubbleCount` out 16: saturating count of bubbles inserted.

## Operation
- **Bubble:** a bubble sets every control bit, `AluOpE`, `FunctE`, all data fields and `ValidE` to 0. With `AluOpE=00`, a bubble drives ALU add with no write-back and no memory effect.
- **Reset:** all outputs are 0 and `BubbleCount` is 0. `LoadUse` evaluates to 0 because `ValidE=0`.
- **`LoadUse` condition:** `LoadUse = ValidE & MemtoRegE & ValidD & (RtE != 0) & ((RtE == RsD) | (RtE == RtD))`.
- **Next-state priority, evaluated every rising edge:**
  1. `Stall=1`: hold all E registers. `Flush` and `LoadUse` are ignored that cycle. The `Flush` requester must keep `Flush` asserted until `Stall` drops.
  2. `Flush=1`: load a bubble and increment `BubbleCount`.
  3. `LoadUse=1`: load a bubble and increment `BubbleCount`. `StallFD=1` keeps the offending instruction in D, so it reissues next cycle.
  4. Otherwise: load all D inputs into E.
- **Flush during a load-use hazard:** `Flush` wins. The single bubble counts once. `StallFD` still follows `LoadUse`, and the upstream squash logic owns D.
- **`BubbleCount` saturation:** holds at 16'hFFFF; it does not wrap. It never increments on hold cycles or on reset.
- **Register 0:** `RtE=0` never triggers `LoadUse`. A load to `$0` is harmless.
- **Invalid D slot:** `ValidD=0` never triggers `LoadUse`. An invalid D slot passes through as-is under case 4.

## Timing
- Latency is one cycle from D inputs to E outputs.
- `LoadUse` and `StallFD` are combinational, from E registers and D inputs, with no registered delay.
- A load-use hazard costs exactly one bubble:
  - Cycle n: load in E, dependent instruction in D; `LoadUse=1`.
  - Cycle n+1: bubble in E, dependent instruction still in D; `LoadUse=0`.
  - Cycle n+2: dependent instruction in E.
- `Reset` asserted mid-operation clears E asynchronously without waiting for a clock edge. The first load occurs on the first rising edge after `Reset` deasserts.
- Simultaneous `Stall`, `Flush` and `LoadUse` resolve to hold, per the priority order above.

## Test plan
- **Reset mid-operation:** load an `add` (`AluOpD=10`, `FunctD=100000`, `RD1D=5`, `RD2D=7`). Next edge gives `AluOpE=10`, `FunctE=100000`, `RD1E=5`, `ValidE=1`. Assert `Reset` between edges → all E outputs 0 immediately, `BubbleCount=0`.
- **Load-use:** `lw` with `MemtoRegD=1`, `RtD=8` enters E; next D instruction has `RsD=8` → `LoadUse=1`, `StallFD=1`. Next edge E is a bubble (`ValidE=0`, `RegWriteE=0`, `AluOpE=00`), `BubbleCount=1`. Following edge the dependent instruction reaches E with `RsE=8`.
- **No false hazards:** `lw` with `RtE=0` and `RsD=0` → `LoadUse=0`. A non-load with `RtE=RsD=9` → `LoadUse=0`. `ValidD=0` with a matching specifier → `LoadUse=0`.
- **Stall over Flush:** E holds `sub` (`FunctE=100010`); assert `Stall=1` and `Flush=1` for 3 cycles → E unchanged, `BubbleCount` unchanged. Drop `Stall`, keep `Flush` one edge → bubble loaded, `BubbleCount` +1.
- **Flush during load-use:** assert `Flush` while `LoadUse=1` → exactly one bubble, `BubbleCount` +1 (not +2).
- **Saturation:** force 65,537 consecutive flushes → `BubbleCount=16'hFFFF`, and it stays there on further flushes.
